// File: rtl/kp_pkg.sv
// Shared constants and enums for the 4x4 keypad scanner.
// Result classes describe what one full scan of the matrix saw.
package kp_pkg;

  localparam int KP_ROWS      = 4;
  localparam int KP_COLS      = 4;
  localparam int KP_CODE_W    = 4;
  localparam int KP_VALID_BIT = 15;
  localparam int KP_HELD_BIT  = 14;

  typedef enum logic {
    S_DRIVE,
    S_SAMPLE
  } scan_state_t;

  typedef enum logic [1:0] {
    R_NONE,
    R_ONE,
    R_MULTI
  } result_t;

endpackage

// File: rtl/kp_debounce.sv
// Accepts a press or release once the same scan result has been seen DEBOUNCE_SCANS times in a row.
// MULTI results never qualify and restart the stability count.
module kp_debounce
  import kp_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_eval,
  input  result_t              i_class,
  input  logic [KP_CODE_W-1:0] i_code,
  input  logic                 i_held,
  output logic                 o_accept_press,
  output logic                 o_accept_release
);

  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_SCANS);

  result_t                r_prevClass;
  logic [KP_CODE_W-1:0]   r_prevCode;
  logic [CNT_W-1:0]       r_cnt;

  logic                   w_same;
  logic [CNT_W-1:0]       w_cntNext;
  logic                   w_stable;

  // A ONE result only matches the previous one if the key code matches too
  always_comb begin
    w_same    = (i_class == r_prevClass) && ((i_class != R_ONE) || (i_code == r_prevCode));
    w_cntNext = r_cnt;
    if (i_class == R_MULTI) begin
      w_cntNext = '0;
    end else if (w_same) begin
      w_cntNext = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);
    end else begin
      w_cntNext = CNT_W'(1);
    end
    w_stable         = (w_cntNext == CNT_MAX);
    o_accept_press   = i_eval && w_stable && (i_class == R_ONE)  && !i_held;
    o_accept_release = i_eval && w_stable && (i_class == R_NONE) &&  i_held;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_prevClass <= R_NONE;
      r_prevCode  <= '0;
      r_cnt       <= '0;
    end else if (i_eval) begin
      r_prevClass <= i_class;
      r_prevCode  <= i_code;
      r_cnt       <= w_cntNext;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks the columns, collects closures per full scan and
// presents a debounced single-key code to the IO read mux.
module keypad_scanner
  import kp_pkg::*;
#(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  row_in,
  output logic [3:0]  col_out,
  input  logic        board_rd,
  output logic [15:0] io_rdata_board
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 2);

  logic [KP_ROWS-1:0]                    r_rowMeta;
  logic [KP_ROWS-1:0]                    r_rowSync;
  scan_state_t                           r_state;
  scan_state_t                           w_stateNext;
  logic [DIV_W-1:0]                      r_div;
  logic [1:0]                            r_col;
  logic [KP_COLS-2:0][KP_ROWS-1:0]       r_acc;
  logic                                  r_rdPrev;
  logic                                  r_valid;
  logic                                  r_held;
  logic [KP_CODE_W-1:0]                  r_code;

  logic [KP_COLS-1:0][KP_ROWS-1:0]       w_scan;
  logic [4:0]                            w_hits;
  logic [KP_CODE_W-1:0]                  w_code;
  result_t                               w_class;
  logic                                  w_eval;
  logic                                  w_press;
  logic                                  w_release;
  logic                                  w_rdRise;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rowMeta <= 4'hF;
      r_rowSync <= 4'hF;
      r_rdPrev  <= 1'b0;
    end else begin
      r_rowMeta <= row_in;
      r_rowSync <= r_rowMeta;
      r_rdPrev  <= board_rd;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      S_DRIVE:  if (r_div == DIV_LAST) w_stateNext = S_SAMPLE;
      S_SAMPLE: w_stateNext = S_DRIVE;
      default:  w_stateNext = S_DRIVE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_DRIVE;
      r_div   <= '0;
      r_col   <= '0;
      r_acc   <= '0;
    end else begin
      r_state <= w_stateNext;
      if (r_state == S_DRIVE) begin
        r_div <= (r_div == DIV_LAST) ? '0 : r_div + DIV_W'(1);
      end else begin
        r_div <= '0;
        r_col <= r_col + 2'd1;
        for (int c = 0; c < KP_COLS - 1; c++) begin
          if (r_col == 2'(c)) r_acc[c] <= ~r_rowSync;
        end
      end
    end
  end

  assign col_out = ~(4'b0001 << r_col);

  // The last column is classified straight from the synchronizer, so it is never stored
  always_comb begin
    w_scan  = {~r_rowSync, r_acc};
    w_hits  = '0;
    w_code  = '0;
    for (int c = 0; c < KP_COLS; c++) begin
      for (int r = 0; r < KP_ROWS; r++) begin
        if (w_scan[c][r]) begin
          w_hits = w_hits + 5'd1;
          w_code = KP_CODE_W'(r * KP_COLS + c);
        end
      end
    end
    if (w_hits == 5'd0)      w_class = R_NONE;
    else if (w_hits == 5'd1) w_class = R_ONE;
    else                     w_class = R_MULTI;
  end

  assign w_eval   = (r_state == S_SAMPLE) && (r_col == 2'd3);
  assign w_rdRise = board_rd && !r_rdPrev;

  kp_debounce #(
    .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
  ) u_debounce (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_eval           (w_eval),
    .i_class          (w_class),
    .i_code           (w_code),
    .i_held           (r_held),
    .o_accept_press   (w_press),
    .o_accept_release (w_release)
  );

  // A new key latching in the same cycle as a read edge keeps valid set
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_held  <= 1'b0;
      r_code  <= '0;
    end else begin
      if (w_press) begin
        r_code  <= w_code;
        r_held  <= 1'b1;
        r_valid <= 1'b1;
      end else if (w_rdRise) begin
        r_valid <= 1'b0;
      end
      if (w_release) r_held <= 1'b0;
    end
  end

  always_comb begin
    io_rdata_board               = '0;
    io_rdata_board[KP_VALID_BIT] = r_valid;
    io_rdata_board[KP_HELD_BIT]  = r_held;
    io_rdata_board[KP_CODE_W-1:0] = r_code;
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad model closes matrix contacts, a scan-level model
// predicts col_out and io_rdata_board every cycle, and directed checks pin key moments.
module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        board_rd = 1'b0;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic [15:0] io_rdata_board;
  logic [15:0] keys = 16'h0000;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  keypad_scanner #(
    .SCAN_DIV       (SCAN_DIV),
    .DEBOUNCE_SCANS (DEB)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .row_in         (row_in),
    .col_out        (col_out),
    .board_rd       (board_rd),
    .io_rdata_board (io_rdata_board)
  );

  // Key (r,c) is bit r*4+c of keys; it pulls row r low while column c is driven low
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && (col_out[c] === 1'b0)) row_in[r] = 1'b0;
  end

  int          n;
  logic [15:0] kd1, kd2, scanBits, colMask;
  int          hist[$];
  int          res, hits, idx, col;
  bit          stable, press, rel, modelReady = 1'b0;
  logic        mValid, mHeld, mRdPrev;
  logic [3:0]  mCode;

  // Model: rows seen at an edge reflect keys two edges earlier; each column is sampled on the
  // last cycle of its SCAN_DIV window and a scan result is judged against the last DEB results
  always @(posedge clk) begin
    if (!rst_n) begin
      n = 0; kd1 = '0; kd2 = '0; scanBits = '0; hist.delete();
      mValid = 0; mHeld = 0; mRdPrev = 0; mCode = '0; modelReady = 1'b1;
    end else begin
      press = 0; rel = 0;
      if (n % SCAN_DIV == SCAN_DIV - 1) begin
        col      = (n / SCAN_DIV) % 4;
        colMask  = 16'h1111 << col;
        scanBits = (scanBits & ~colMask) | (kd2 & colMask);
        if (col == 3) begin
          hits = $countones(scanBits);
          idx  = 0;
          for (int i = 0; i < 16; i++) if (scanBits[i]) idx = i;
          res = (hits == 0) ? 0 : (hits == 1) ? 16 + idx : 32;
          hist.push_back(res);
          if (hist.size() > DEB) void'(hist.pop_front());
          stable = (hist.size() == DEB);
          foreach (hist[i]) if (hist[i] != res) stable = 0;
          press = stable && res >= 16 && res < 32 && !mHeld;
          rel   = stable && res == 0 && mHeld;
          if (press) begin mCode = 4'(res % 16); mHeld = 1; end
          if (rel) mHeld = 0;
        end
      end
      if (press) mValid = 1;
      else if (board_rd && !mRdPrev) mValid = 0;
      mRdPrev = board_rd;
      kd2 = kd1; kd1 = keys;
      n++;
    end
  end

  logic [3:0]  expCol;
  logic [15:0] expIo;
  always @(negedge clk) begin
    if (modelReady) begin
      expCol = ~(4'b0001 << ((n / SCAN_DIV) % 4));
      expIo  = {mValid, mHeld, 10'b0, mCode};
      total++;
      if (col_out !== expCol) begin
        bad++;
        $display("[TB] FAIL model_col t=%0t got=%b exp=%b", $time, col_out, expCol);
      end
      total++;
      if (io_rdata_board !== expIo) begin
        bad++;
        $display("[TB] FAIL model_io t=%0t got=%h exp=%h", $time, io_rdata_board, expIo);
      end
    end
  end

  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [15:0] keyVal, input int cycles);
    keys = keyVal;
    tick(cycles);
  endtask

  task automatic checkOutput(input string name, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  initial begin
    tick(3);
    checkOutput("reset_col", {12'h0, col_out}, 16'h000E);
    checkOutput("reset_io", io_rdata_board, 16'h0000);
    rst_n = 1'b1;
    tick(4);  checkOutput("walk_col1", {12'h0, col_out}, 16'h000D);
    tick(4);  checkOutput("walk_col2", {12'h0, col_out}, 16'h000B);
    tick(4);  checkOutput("walk_col3", {12'h0, col_out}, 16'h0007);
    tick(4);  checkOutput("walk_wrap", {12'h0, col_out}, 16'h000E);

    applyStimulus(16'h0200, 48);
    checkOutput("press_r2c1", io_rdata_board, 16'hC009);

    board_rd = 1'b1;
    tick(1);  checkOutput("read_clear", io_rdata_board, 16'h4009);
    tick(16); checkOutput("read_level_hold", io_rdata_board, 16'h4009);
    applyStimulus(16'h0000, 48);
    checkOutput("release", io_rdata_board, 16'h0009);
    board_rd = 1'b0;

    rst_n = 1'b0;
    tick(2);  checkOutput("reset2_io", io_rdata_board, 16'h0000);
    rst_n = 1'b1;
    tick(16);
    applyStimulus(16'h0080, 16);
    applyStimulus(16'h0000, 32);
    checkOutput("bounce_ignored", io_rdata_board, 16'h0000);
    applyStimulus(16'h8001, 48);
    checkOutput("multi_ignored", io_rdata_board, 16'h0000);
    applyStimulus(16'h0000, 32);

    applyStimulus(16'h0020, 31);
    board_rd = 1'b1;
    tick(1);  checkOutput("set_wins_clear", io_rdata_board, 16'hC005);

    tick(9);  checkOutput("midscan_col", {12'h0, col_out}, 16'h000B);
    rst_n = 1'b0;
    tick(1);
    checkOutput("midreset_col", {12'h0, col_out}, 16'h000E);
    checkOutput("midreset_io", io_rdata_board, 16'h0000);
    rst_n = 1'b1;
    board_rd = 1'b0;
    tick(40); checkOutput("relatch", io_rdata_board, 16'hC005);

    tick(5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
